// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one uart_tx serializer between NREQ byte producers. Generates the
// serializer's bit_clk strobe, arbitrates pending requests, runs the
// send/done handshake (including the send-low release tick) and returns a
// one-cycle ack to the producer whose byte completed.
//
// Configuration macro:
//   UART_TX_ARB_PRIO_EN  defined   -> fixed priority, lowest set req wins.
//                        undefined -> round-robin starting at the rr pointer.
//   Handshake timing is identical in both builds.
//
// Ports:
//   ref_clk   in   1        system clock
//   reset     in   1        asynchronous active-high reset
//   req       in   NREQ     request level per producer, held until ack
//   req_data  in   NREQ*8   byte per producer, slot i = [8i+7:8i]
//   ack       out  NREQ     one-cycle pulse, byte of that requester sent
//   busy      out  1        a byte is granted and in flight
//   grant_id  out  3        index of the current/last winner
//   bit_clk   out  1        one-cycle strobe every DIV ref_clk cycles
//   tx_send   out  1        uart_tx send
//   tx_data   out  8        uart_tx data input
//   tx_done   in   1        uart_tx done
// ---------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int NREQ = 4,
    parameter int DIV  = 434,
    parameter int DIVW = 9
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              bit_clk,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    input  logic              tx_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DIVW-1:0]   cnt_q;
    logic [DIVW-1:0]   cnt_d;
    logic              bit_clk_q;
    logic [NREQ-1:0]   ack_q;
    logic              busy_q;
    logic [2:0]        grant_id_q;
    logic              tx_send_q;
    logic [7:0]        tx_data_q;

    logic              win_found;
    logic [2:0]        win_idx;
    logic [7:0]        win_data;

    // -----------------------------------------------------------------------
    // Bit-period divider: free-running, independent of the FSM. The strobe
    // is registered from the wrap condition, so the first pulse lands DIV
    // cycles after reset release and then repeats every DIV cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d = (cnt_q == DIVW'(DIV - 1)) ? '0 : cnt_q + DIVW'(1);
    end

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            bit_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_clk_q <= (cnt_q == DIVW'(DIV - 1));
        end
    end

    // -----------------------------------------------------------------------
    // Winner selection (combinational, consumed only on IDLE ticks).
    // -----------------------------------------------------------------------
`ifdef UART_TX_ARB_PRIO_EN
    // Fixed priority: scanning downward leaves the lowest set index.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_data  = req_data[8*i +: 8];
            end
        end
    end
`else
    logic [2:0] rr_q;
    logic       hi_found;
    logic [2:0] hi_idx;
    logic [7:0] hi_data;
    logic       lo_found;
    logic [2:0] lo_idx;
    logic [7:0] lo_data;

    // Round-robin without a variable-index rotate: take the lowest set index
    // at or above the pointer, else wrap to the lowest set index overall.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        hi_found = 1'b0;
        hi_idx   = '0;
        hi_data  = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        lo_data  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = 3'(i);
                lo_data  = req_data[8*i +: 8];
                if (3'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                    hi_data  = req_data[8*i +: 8];
                end
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx  : lo_idx;
        win_data  = hi_found ? hi_data : lo_data;
    end
`endif

    // -----------------------------------------------------------------------
    // Handshake FSM. Everything advances only on bit_clk ticks, so tx_send
    // only changes on the edge closing a tick and tx_done is only looked at
    // in tick cycles. tx_done seen in IDLE or REL has no effect.
    // -----------------------------------------------------------------------
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            tx_send_q  <= 1'b0;
            tx_data_q  <= '0;
`ifndef UART_TX_ARB_PRIO_EN
            rr_q       <= '0;
`endif
        end else begin
            ack_q <= '0;
            if (bit_clk_q) begin
                case (state_q)
                    IDLE: begin
                        if (win_found) begin
                            grant_id_q <= win_idx;
                            tx_data_q  <= win_data;
                            busy_q     <= 1'b1;
                            tx_send_q  <= 1'b1;
                            state_q    <= SEND;
                        end
                    end
                    SEND: begin
                        if (tx_done) begin
                            tx_send_q <= 1'b0;
                            state_q   <= REL;
                        end
                    end
                    REL: begin
                        // Send has been low for one full tick; the
                        // serializer has released, so the byte is complete.
                        for (int i = 0; i < NREQ; i++) begin
                            ack_q[i] <= (grant_id_q == 3'(i));
                        end
                        busy_q  <= 1'b0;
`ifndef UART_TX_ARB_PRIO_EN
                        rr_q    <= (grant_id_q == 3'(NREQ - 1)) ? 3'd0
                                                                : grant_id_q + 3'd1;
`endif
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign bit_clk  = bit_clk_q;
    assign tx_send  = tx_send_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Directed bench for uart_tx_arb with NREQ=4, DIV=4. A small serializer
// model raises tx_done after tx_send has been high for ten bit_clk ticks,
// giving 12 bit periods (48 ref_clk cycles) between back-to-back grants.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NREQ = 4;
    localparam int DIV  = 4;
    localparam int DIVW = 3;

    logic              ref_clk = 1'b0;
    logic              reset   = 1'b1;
    logic [NREQ-1:0]   req      = '0;
    logic [NREQ*8-1:0] req_data = '0;
    logic [NREQ-1:0]   ack;
    logic              busy;
    logic [2:0]        grant_id;
    logic              bit_clk;
    logic              tx_send;
    logic [7:0]        tx_data;
    logic              tx_done = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic force_done = 1'b0;
    int   fcnt   = 0;

    uart_tx_arb #(
        .NREQ (NREQ),
        .DIV  (DIV),
        .DIVW (DIVW)
    ) dut (
        .ref_clk  (ref_clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .bit_clk  (bit_clk),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) cyc = cyc + 1;

    // Serializer model: counts ticks with send high, reports done on the
    // tenth one and keeps it until send is released.
    always @(negedge ref_clk) begin
        if (!tx_send) fcnt = 0;
        else if (bit_clk && fcnt < 10) fcnt = fcnt + 1;
        tx_done = force_done || (tx_send && fcnt >= 10);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge ref_clk);
        @(negedge ref_clk);
        reset = 1'b0;
    endtask

    // One complete frame for requester id carrying data: grant, 10 ticks of
    // send, one send-low release tick, then a single-cycle ack.
    task automatic run_frame(input int id, input logic [7:0] data,
                             input string name, output int gcyc);
        int  n;
        int  ticks;
        bit  seen;
        gcyc = 0;
        seen = 0;
        for (n = 0; n < 40 && !seen; n++) begin
            @(negedge ref_clk);
            if (tx_send === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s start: tx_send stayed %b, want 1", name, tx_send);
            return;
        end
        gcyc = cyc;
        checks++;
        if (grant_id !== 3'(id) || tx_data !== data || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s grant: got id=%0d data=%h busy=%b, want id=%0d data=%h busy=1",
                     name, grant_id, tx_data, busy, id, data);
        end
        ticks = 0;
        n = 0;
        while (tx_send === 1'b1 && n < 200) begin
            if (bit_clk) ticks++;
            @(negedge ref_clk);
            n++;
        end
        checks++;
        if (tx_send !== 1'b0 || ticks != 10) begin
            errors++;
            $display("FAIL %s send_len: got %0d ticks send=%b, want 10 ticks send=0",
                     name, ticks, tx_send);
        end
        ticks = 0;
        n = 0;
        while (ack === '0 && n < 100) begin
            if (bit_clk) ticks++;
            @(negedge ref_clk);
            n++;
        end
        checks++;
        if (ack !== 4'(1 << id) || busy !== 1'b0 || tx_send !== 1'b0 || ticks != 1) begin
            errors++;
            $display("FAIL %s release: got ack=%b busy=%b send=%b rel_ticks=%0d, want ack=%b busy=0 send=0 rel_ticks=1",
                     name, ack, busy, tx_send, ticks, 4'(1 << id));
        end
        @(negedge ref_clk);
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("FAIL %s ack_pulse: got ack=%b one cycle later, want 0000", name, ack);
        end
    endtask

    task automatic test_reset();
        bit quiet;
        reset = 1'b1;
        req   = '0;
        repeat (3) @(negedge ref_clk);
        checks++;
        if ({ack, busy, grant_id, bit_clk, tx_send, tx_data} !== '0) begin
            errors++;
            $display("FAIL reset_values: got ack=%b busy=%b id=%0d bclk=%b send=%b data=%h, want all 0",
                     ack, busy, grant_id, bit_clk, tx_send, tx_data);
        end
        reset = 1'b0;
        quiet = 1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge ref_clk);
            checks++;
            if (bit_clk !== ((k % DIV) == 0)) begin
                errors++;
                $display("FAIL reset_bit_clk: cycle %0d got %b, want %b",
                         k, bit_clk, (k % DIV) == 0);
            end
            if (tx_send !== 1'b0 || busy !== 1'b0 || ack !== '0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_quiet: got activity on send/busy/ack with no req, want none");
        end
    endtask

    task automatic test_single();
        int g;
        do_reset();
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        run_frame(2, 8'hA5, "single", g);
        req = '0;
    endtask

`ifdef UART_TX_ARB_PRIO_EN
    task automatic test_arbitration();
        int g;
        int g_prev;
        do_reset();
        req_data = 32'h44_33_22_11;
        req = 4'b1010;
        run_frame(1, 8'h22, "prio0", g_prev);
        for (int k = 1; k < 3; k++) begin
            run_frame(1, 8'h22, "prio_rep", g);
            checks++;
            if (g - g_prev != 12 * DIV) begin
                errors++;
                $display("FAIL prio_spacing: got %0d cycles, want %0d", g - g_prev, 12 * DIV);
            end
            g_prev = g;
        end
        req = 4'b1000;
        run_frame(3, 8'h44, "prio_low", g);
        req = '0;
    endtask
`else
    task automatic test_arbitration();
        int          g;
        int          g_prev;
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [7:0]  bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        req_data = 32'h44_33_22_11;
        req = 4'b1111;
        run_frame(order[0], bytes[order[0]], "rr0", g_prev);
        for (int k = 1; k < 5; k++) begin
            run_frame(order[k], bytes[order[k]], "rr", g);
            checks++;
            if (g - g_prev != 12 * DIV) begin
                errors++;
                $display("FAIL rr_spacing: grant %0d got %0d cycles, want %0d",
                         k, g - g_prev, 12 * DIV);
            end
            g_prev = g;
        end
        req = '0;
    endtask
`endif

    task automatic test_reset_mid_frame();
        int  n;
        int  ticks;
        int  g;
        bit  seen;
        bit  quiet;
        do_reset();
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        seen = 0;
        for (n = 0; n < 40 && !seen; n++) begin
            @(negedge ref_clk);
            if (tx_send === 1'b1) seen = 1;
        end
        ticks = 0;
        n = 0;
        while (ticks < 5 && n < 100) begin
            @(negedge ref_clk);
            if (bit_clk) ticks++;
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (seen != 1 || tx_send !== 1'b0 || busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL midreset_async: started=%0d got send=%b busy=%b ack=%b, want started=1 send=0 busy=0 ack=0000",
                     seen, tx_send, busy, ack);
        end
        repeat (2) @(negedge ref_clk);
        req = '0;
        reset = 1'b0;
        quiet = 1;
        repeat (60) begin
            @(negedge ref_clk);
            if (ack !== '0 || tx_send !== 1'b0 || busy !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midreset_noack: got ack/send/busy activity after abort, want none");
        end
        req_data[15:8] = 8'hC3;
        req = 4'b0010;
        run_frame(1, 8'hC3, "after_reset", g);
        req = '0;
    endtask

    task automatic test_done_in_idle();
        bit quiet;
        int g;
        force_done = 1'b1;
        quiet = 1;
        repeat (40) begin
            @(negedge ref_clk);
            if (ack !== '0 || busy !== 1'b0 || tx_send !== 1'b0 || grant_id !== 3'd1) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL idle_done: got ack=%b busy=%b send=%b id=%0d, want ack=0000 busy=0 send=0 id=1",
                     ack, busy, tx_send, grant_id);
        end
        force_done = 1'b0;
        @(negedge ref_clk);
        req_data[31:24] = 8'h5A;
        req = 4'b1000;
        run_frame(3, 8'h5A, "idle_done_next", g);
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_reset_mid_frame();
        test_done_in_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
